// File: rtl/clb_param_pkg.sv
// Shared definitions for the parametrised CLB tile.
// Holds the width derivations, the per-BLE configuration field layout and the
// ble_cfg_t struct with pack/unpack helpers. The RTL and the bench bitstream
// builder both use these helpers.
// Optional feature macro: CLB_FF_INIT_EN adds one init bit per BLE.
package clb_param_pkg;

  localparam int unsigned MaxLutK  = 6;
  localparam int unsigned MaxSelW  = 8;
  localparam int unsigned MaxMaskW = 64;
  localparam int unsigned MaskIdxW = 6;
`ifdef CLB_FF_INIT_EN
  localparam int unsigned InitW = 1;
`else
  localparam int unsigned InitW = 0;
`endif
  localparam int unsigned MaxBleCfgW = MaxLutK * MaxSelW + MaxMaskW + 2 + InitW;
  localparam int unsigned BitIdxW    = 7;

  typedef enum logic [2:0] {FldSel, FldMask, FldBypass, FldCarry, FldInit} cfg_field_e;

  // Sized for the largest legal BLE; unused upper bits stay zero.
  typedef struct packed {
    logic [MaxLutK-1:0][MaxSelW-1:0] sel;
    logic [MaxMaskW-1:0]             mask;
    logic                            bypass;
    logic                            carry_mode;
    logic                            init;
  } ble_cfg_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  function automatic int unsigned sel_width(input int unsigned num_in, input int unsigned num_ble);
    return clog2(num_in + num_ble);
  endfunction

  function automatic int unsigned ble_cfg_width(input int unsigned lut_k,
                                                input int unsigned sel_w);
    return lut_k * sel_w + (32'd1 << lut_k) + 2 + InitW;
  endfunction

  function automatic int unsigned cfg_width(input int unsigned num_ble,
                                            input int unsigned ble_cfg_w);
    return num_ble * ble_cfg_w;
  endfunction

  // Bit offset of the first bit of a field inside the whole tile config.
  function automatic int unsigned field_offset(input int unsigned ble, input int unsigned lut_k,
                                               input int unsigned sel_w, input cfg_field_e fld);
    int unsigned base;
    int unsigned off;
    base = ble * ble_cfg_width(lut_k, sel_w);
    off  = base;
    case (fld)
      FldSel:    off = base;
      FldMask:   off = base + lut_k * sel_w;
      FldBypass: off = base + lut_k * sel_w + (32'd1 << lut_k);
      FldCarry:  off = base + lut_k * sel_w + (32'd1 << lut_k) + 1;
      FldInit:   off = base + lut_k * sel_w + (32'd1 << lut_k) + 2;
      default:   off = base;
    endcase
    return off;
  endfunction

  function automatic ble_cfg_t unpack_ble(input logic [MaxBleCfgW-1:0] bits,
                                          input int unsigned lut_k, input int unsigned sel_w);
    ble_cfg_t    s;
    int unsigned idx;
    s = '0;
    for (int unsigned i = 0; i < MaxLutK; i++) begin
      for (int unsigned j = 0; j < MaxSelW; j++) begin
        if (i < lut_k && j < sel_w) begin
          idx = i * sel_w + j;
          s.sel[3'(i)][3'(j)] = bits[BitIdxW'(idx)];
        end
      end
    end
    for (int unsigned j = 0; j < MaxMaskW; j++) begin
      if (j < (32'd1 << lut_k)) begin
        idx = field_offset(0, lut_k, sel_w, FldMask) + j;
        s.mask[MaskIdxW'(j)] = bits[BitIdxW'(idx)];
      end
    end
    s.bypass     = bits[BitIdxW'(field_offset(0, lut_k, sel_w, FldBypass))];
    s.carry_mode = bits[BitIdxW'(field_offset(0, lut_k, sel_w, FldCarry))];
    if (InitW != 0) s.init = bits[BitIdxW'(field_offset(0, lut_k, sel_w, FldInit))];
    return s;
  endfunction

  function automatic logic [MaxBleCfgW-1:0] pack_ble(input ble_cfg_t s, input int unsigned lut_k,
                                                     input int unsigned sel_w);
    logic [MaxBleCfgW-1:0] bits;
    int unsigned           idx;
    bits = '0;
    for (int unsigned i = 0; i < MaxLutK; i++) begin
      for (int unsigned j = 0; j < MaxSelW; j++) begin
        if (i < lut_k && j < sel_w) begin
          idx = i * sel_w + j;
          bits[BitIdxW'(idx)] = s.sel[3'(i)][3'(j)];
        end
      end
    end
    for (int unsigned j = 0; j < MaxMaskW; j++) begin
      if (j < (32'd1 << lut_k)) begin
        idx = field_offset(0, lut_k, sel_w, FldMask) + j;
        bits[BitIdxW'(idx)] = s.mask[MaskIdxW'(j)];
      end
    end
    bits[BitIdxW'(field_offset(0, lut_k, sel_w, FldBypass))] = s.bypass;
    bits[BitIdxW'(field_offset(0, lut_k, sel_w, FldCarry))]  = s.carry_mode;
    if (InitW != 0) bits[BitIdxW'(field_offset(0, lut_k, sel_w, FldInit))] = s.init;
    return bits;
  endfunction

endpackage

// File: rtl/clb_param_tile_if.sv
// Tile-level signal bundle for clb_param_tile.
//   in, cin           : user data inputs and carry in
//   config_en         : shift enable for the serial config chain
//   ccff_head         : serial config input
//   out, cout         : BLE outputs and carry out of the last BLE
//   ccff_tail         : serial config output
//   config_done       : full-length load finished
// master = driver of the tile (environment), slave = the tile itself.
interface clb_param_tile_if #(
  parameter int unsigned NUM_IN  = 8,
  parameter int unsigned NUM_BLE = 4
);
  logic [NUM_IN-1:0]  in;
  logic               cin;
  logic               config_en;
  logic               ccff_head;
  logic [NUM_BLE-1:0] out;
  logic               cout;
  logic               ccff_tail;
  logic               config_done;

  modport master (
    output in, cin, config_en, ccff_head,
    input  out, cout, ccff_tail, config_done
  );

  modport slave (
    input  in, cin, config_en, ccff_head,
    output out, cout, ccff_tail, config_done
  );
endinterface

// File: rtl/clb_param_ble.sv
// One basic logic element: local crossbar, LUT_K-input LUT, mux carry stage,
// output flip-flop and bypass mux.
// Ports:
//   clk, reset          : user clock, synchronous active-high reset
//   cfg_bits            : this BLE's slice of the tile configuration
//   tile_in, ff_fb      : crossbar sources (tile inputs, registered BLE outputs)
//   config_en           : freezes the FF and forces out low
//   load_init, init_val : FF preload (reset value and load-complete preload)
//   c_in, c_out         : carry chain
//   ff_q, out           : registered value and BLE output
module clb_param_ble
  import clb_param_pkg::*;
#(
  parameter int unsigned NUM_IN  = 8,
  parameter int unsigned NUM_BLE = 4,
  parameter int unsigned LUT_K   = 4,
  localparam int unsigned SEL_W     = sel_width(NUM_IN, NUM_BLE),
  localparam int unsigned BLE_CFG_W = ble_cfg_width(LUT_K, SEL_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BLE_CFG_W-1:0] cfg_bits,
  input  logic [NUM_IN-1:0]    tile_in,
  input  logic [NUM_BLE-1:0]   ff_fb,
  input  logic                 config_en,
  input  logic                 load_init,
  input  logic                 init_val,
  input  logic                 c_in,
  output logic                 c_out,
  output logic                 ff_q,
  output logic                 out
);

  localparam int unsigned NSrc = NUM_IN + NUM_BLE;

  ble_cfg_t            ble_cfg;
  logic [NSrc-1:0]     src;
  logic [LUT_K-1:0]    lut_in;
  logic                lut;
  logic                comb;

  assign ble_cfg = unpack_ble(MaxBleCfgW'(cfg_bits), LUT_K, SEL_W);
  assign src     = {ff_fb, tile_in};

  // Out-of-range selects read as constant 0.
  for (genvar k = 0; k < LUT_K; k++) begin : g_xbar
    logic [SEL_W-1:0] v;
    assign v         = ble_cfg.sel[k][SEL_W-1:0];
    assign lut_in[k] = ({1'b0, v} < (SEL_W + 1)'(NSrc)) ? src[v] : 1'b0;
  end

  assign lut = ble_cfg.mask[MaskIdxW'(lut_in)];

  always_comb begin
    comb  = lut;
    c_out = c_in;
    if (ble_cfg.carry_mode) begin
      comb  = lut ^ c_in;
      c_out = lut ? c_in : lut_in[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= init_val;
    end else if (load_init) begin
      ff_q <= init_val;
    end else if (!config_en) begin
      ff_q <= comb;
    end
  end

  assign out = config_en ? 1'b0 : (ble_cfg.bypass ? comb : ff_q);

endmodule

// File: rtl/clb_param_tile.sv
// Parametrised CLB tile: NUM_BLE BLEs fed by local crossbars, chained through
// carry, configured by a serial shift chain on the user clock.
// Ports:
//   clk   : single clock for config shifting and user logic
//   reset : synchronous, active-high
//   bus   : clb_param_tile_if.slave (in, cin, config_en, ccff_head,
//           out, cout, ccff_tail, config_done)
// Optional feature macro: CLB_FF_INIT_EN (per-BLE FF init value, loaded on
// reset and when a full configuration load completes).
module clb_param_tile
  import clb_param_pkg::*;
#(
  parameter int unsigned NUM_IN  = 8,
  parameter int unsigned NUM_BLE = 4,
  parameter int unsigned LUT_K   = 4
) (
  input logic           clk,
  input logic           reset,
  clb_param_tile_if.slave bus
);

  localparam int unsigned SEL_W     = sel_width(NUM_IN, NUM_BLE);
  localparam int unsigned BLE_CFG_W = ble_cfg_width(LUT_K, SEL_W);
  localparam int unsigned CFG_W     = cfg_width(NUM_BLE, BLE_CFG_W);
  localparam int unsigned CountW    = clog2(CFG_W + 1);

  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [CountW-1:0]  count_q, count_d;
  logic               en_prev_q;
  logic               done_q, done_d;
  logic               load_init;
  logic [NUM_BLE-1:0] init_val;
  logic [NUM_BLE-1:0] ff_q;
  logic [NUM_BLE-1:0] ble_out;
  logic [NUM_BLE:0]   carry;

  // A config_en rising edge restarts the count, so an interrupted load never
  // reports done.
  always_comb begin
    cfg_d   = cfg_q;
    count_d = count_q;
    if (bus.config_en) begin
      cfg_d = {cfg_q[CFG_W-2:0], bus.ccff_head};
      if (!en_prev_q) begin
        count_d = CountW'(1);
      end else if (count_q < CountW'(CFG_W)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  assign done_d = (count_d == CountW'(CFG_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q     <= '0;
      count_q   <= '0;
      en_prev_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      count_q   <= count_d;
      en_prev_q <= bus.config_en;
      done_q    <= done_d;
    end
  end

`ifdef CLB_FF_INIT_EN
  // Reset uses the init bits held before the edge; load completion uses the
  // bits that arrive with the final shift.
  for (genvar b = 0; b < NUM_BLE; b++) begin : g_init
    localparam int unsigned InitOff = field_offset(b, LUT_K, SEL_W, FldInit);
    assign init_val[b] = reset ? cfg_q[InitOff] : cfg_d[InitOff];
  end
  assign load_init = done_d & ~done_q;
`else
  assign init_val  = '0;
  assign load_init = 1'b0;
`endif

  assign carry[0] = bus.cin;

  for (genvar b = 0; b < NUM_BLE; b++) begin : g_ble
    clb_param_ble #(
      .NUM_IN (NUM_IN),
      .NUM_BLE(NUM_BLE),
      .LUT_K  (LUT_K)
    ) u_ble (
      .clk      (clk),
      .reset    (reset),
      .cfg_bits (cfg_q[b*BLE_CFG_W +: BLE_CFG_W]),
      .tile_in  (bus.in),
      .ff_fb    (ff_q),
      .config_en(bus.config_en),
      .load_init(load_init),
      .init_val (init_val[b]),
      .c_in     (carry[b]),
      .c_out    (carry[b+1]),
      .ff_q     (ff_q[b]),
      .out      (ble_out[b])
    );
  end

  assign bus.out         = ble_out;
  assign bus.cout        = carry[NUM_BLE];
  assign bus.ccff_tail   = cfg_q[CFG_W-1];
  assign bus.config_done = done_q;

endmodule

// File: tb/tb_clb_param_tile.sv
// Scoreboard bench for clb_param_tile (default parameters).
module tb_clb_param_tile;
  import clb_param_pkg::*;

  localparam int unsigned NumIn  = 8;
  localparam int unsigned NumBle = 4;
  localparam int unsigned LutK   = 4;
  localparam int unsigned SelW   = sel_width(NumIn, NumBle);
  localparam int unsigned BleW   = ble_cfg_width(LutK, SelW);
  localparam int unsigned CfgW   = cfg_width(NumBle, BleW);

  logic clk;
  logic reset;

  clb_param_tile_if #(.NUM_IN(NumIn), .NUM_BLE(NumBle)) bus ();

  clb_param_tile #(
    .NUM_IN (NumIn),
    .NUM_BLE(NumBle),
    .LUT_K  (LutK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t             exp_q[$];
  int unsigned      n_checks;
  int unsigned      n_fail;
  ble_cfg_t         ble_cfg[NumBle];
  logic [CfgW-1:0]  stream;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs, e.value);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.config_en = 1'b0;
    bus.ccff_head = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic clr_cfgs();
    for (int b = 0; b < NumBle; b++) ble_cfg[b] = '0;
  endtask

  task automatic build_stream();
    logic [MaxBleCfgW-1:0] bits;
    stream = '0;
    for (int b = 0; b < NumBle; b++) begin
      bits = pack_ble(ble_cfg[b], LutK, SelW);
      for (int j = 0; j < BleW; j++) stream[b*BleW + j] = bits[j];
    end
  endtask

  // Shifts stream MSB first, checking config_done after every shift.
  task automatic load_stream();
    for (int i = CfgW - 1; i >= 0; i--) begin
      bus.ccff_head = stream[i];
      bus.config_en = 1'b1;
      sb_push("load_done", (i == 0) ? 32'd1 : 32'd0);
      step();
      sb_pop(32'(bus.config_done));
    end
    bus.config_en = 1'b0;
    bus.ccff_head = 1'b0;
  endtask

  function automatic logic walk_bit(input int j);
    return ((j % 7) == ((j / 7) % 7));
  endfunction

  initial begin
    int unsigned a, b, c, sum;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.in   = '0;
    bus.cin  = 1'b1;
    bus.config_en = 1'b0;
    bus.ccff_head = 1'b0;

    // Reset state
    do_reset();
    sb_push("rst_out", 32'd0);
    sb_push("rst_cout", 32'd1);
    sb_push("rst_tail", 32'd0);
    sb_push("rst_done", 32'd0);
    #1;
    sb_pop(32'(bus.out));
    sb_pop(32'(bus.cout));
    sb_pop(32'(bus.ccff_tail));
    sb_pop(32'(bus.config_done));

    // Walking pattern through the chain, continuing past a full load
    for (int j = 0; j < int'(CfgW) + 20; j++) begin
      bus.ccff_head = walk_bit(j);
      bus.config_en = 1'b1;
      sb_push("shift_tail", (j + 1 >= int'(CfgW)) ? 32'(walk_bit(j + 1 - int'(CfgW))) : 32'd0);
      sb_push("shift_done", (j + 1 >= int'(CfgW)) ? 32'd1 : 32'd0);
      sb_push("shift_out", 32'd0);
      step();
      sb_pop(32'(bus.ccff_tail));
      sb_pop(32'(bus.config_done));
      sb_pop(32'(bus.out));
    end

    // BLE0 4-input AND (bypass), BLE1 toggling through its own FF
    do_reset();
    bus.cin = 1'b0;
    clr_cfgs();
    for (int k = 0; k < 4; k++) ble_cfg[0].sel[k] = 8'(k);
    ble_cfg[0].mask   = 64'h8000;
    ble_cfg[0].bypass = 1'b1;
    ble_cfg[1].sel[0] = 8'd9;
    for (int k = 1; k < 4; k++) ble_cfg[1].sel[k] = 8'd15;
    ble_cfg[1].mask   = 64'h5555;
    build_stream();
    load_stream();
    sb_push("toggle_pre", 32'd0);
    #1;
    sb_pop(32'(bus.out[1]));
    for (int t = 0; t < 4; t++) begin
      sb_push("toggle", (t % 2 == 0) ? 32'd1 : 32'd0);
      step();
      sb_pop(32'(bus.out[1]));
    end
    bus.in = 8'h0F;
    sb_push("and_0f", 32'd1);
    #1;
    sb_pop(32'(bus.out[0]));
    bus.in = 8'h07;
    sb_push("and_07", 32'd0);
    #1;
    sb_pop(32'(bus.out[0]));
    // config_en forces out low even with a bypassed LUT at 1
    bus.in = 8'h0F;
    bus.config_en = 1'b1;
    sb_push("cfg_force_out", 32'd0);
    #1;
    sb_pop(32'(bus.out));

    // 4-bit ripple adder
    do_reset();
    clr_cfgs();
    for (int bl = 0; bl < 4; bl++) begin
      ble_cfg[bl].sel[0]     = 8'(bl);
      ble_cfg[bl].sel[1]     = 8'(4 + bl);
      ble_cfg[bl].sel[2]     = 8'd15;
      ble_cfg[bl].sel[3]     = 8'd15;
      ble_cfg[bl].mask       = 64'h6666;
      ble_cfg[bl].carry_mode = 1'b1;
      ble_cfg[bl].bypass     = 1'b1;
    end
    build_stream();
    load_stream();
    for (int v = 0; v < 10; v++) begin
      if (v == 0) begin a = 15; b = 1; c = 0; end
      else if (v == 1) begin a = 5; b = 3; c = 0; end
      else begin a = $urandom_range(15); b = $urandom_range(15); c = $urandom_range(1); end
      sum = a + b + c;
      bus.in  = {4'(b), 4'(a)};
      bus.cin = c[0];
      sb_push("add_sum", sum & 32'hF);
      sb_push("add_cout", (sum >> 4) & 32'd1);
      #1;
      sb_pop(32'(bus.out));
      sb_pop(32'(bus.cout));
    end

    // Reset part-way through a load, simultaneous with config_en
    bus.in = '0;
    for (int j = 0; j < 50; j++) begin
      bus.ccff_head = 1'b1;
      bus.config_en = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.config_en = 1'b0;
    bus.cin = 1'b1;
    sb_push("mid_rst_tail", 32'd0);
    sb_push("mid_rst_done", 32'd0);
    sb_push("mid_rst_cout1", 32'd1);
    sb_push("mid_rst_out", 32'd0);
    #1;
    sb_pop(32'(bus.ccff_tail));
    sb_pop(32'(bus.config_done));
    sb_pop(32'(bus.cout));
    sb_pop(32'(bus.out));
    bus.cin = 1'b0;
    sb_push("mid_rst_cout0", 32'd0);
    #1;
    sb_pop(32'(bus.cout));
    step();

    // Aborted load, then a fresh full load of the adder
    for (int j = 0; j < 60; j++) begin
      bus.ccff_head = 1'b0;
      bus.config_en = 1'b1;
      sb_push("abort_done", 32'd0);
      step();
      sb_pop(32'(bus.config_done));
    end
    bus.config_en = 1'b0;
    sb_push("paused_done", 32'd0);
    step();
    sb_pop(32'(bus.config_done));
    load_stream();
    bus.in  = {4'd6, 4'd7};
    bus.cin = 1'b1;
    sb_push("reload_sum", 32'd14);
    sb_push("reload_cout", 32'd0);
    #1;
    sb_pop(32'(bus.out));
    sb_pop(32'(bus.cout));

    if (exp_q.size() != 0) check_eq("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
